// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command issuer: op encodings, FSM states,
// immediate sign extension and the default register count.
package alu_seq_pkg;

  localparam int unsigned NREG_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic op_defined(input logic [2:0] op);
    return (op <= OP_SRA);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU driven by alu_seq; lives beside it at the
// integrating level. Undefined ops return zero.
module alu
  import alu_seq_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C
);

  // Shift amounts use all 32 bits of B, so B >= 32 drains or sign-fills fully.
  always_comb begin
    C = '0;
    case (ALUOp)
      OP_ADD:  C = A + B;
      OP_SUB:  C = A - B;
      OP_AND:  C = A & B;
      OP_OR:   C = A | B;
      OP_SRL:  C = A >> B;
      OP_SRA:  C = $signed(A) >>> B;
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_rf.sv
// NREG x 32 register file: one synchronous write port, two operand read
// ports and a debug read port, all combinational; R0 always reads zero.
module alu_seq_rf
  import alu_seq_pkg::*;
#(
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  output logic [31:0]   rdata_a_o,
  input  logic [RW-1:0] raddr_b_i,
  output logic [31:0]   rdata_b_o,
  input  logic [RW-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o
);

  logic [31:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq.sv
// Command-driven issuer: accepts reg/reg or reg/imm commands, drives operands
// to an external ALU for one EXEC cycle and writes the result back.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int unsigned NREG  = NREG_DEF,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [RW-1:0]    cmd_rs,
  input  logic [RW-1:0]    cmd_rt,
  input  logic             cmd_imm_en,
  input  logic [15:0]      cmd_imm,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_C,
  output logic             wb_valid,
  output logic [RW-1:0]    wb_addr,
  output logic [31:0]      wb_data,
  input  logic [RW-1:0]    dbg_addr,
  output logic [31:0]      dbg_data,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RW-1:0]    wb_addr_q, wb_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             exec;
  logic [31:0]      rf_a, rf_b;

  alu_seq_rf #(.NREG(NREG)) u_rf (
    .clk        (clk),
    .reset      (reset),
    .we_i       (exec),
    .waddr_i    (rd_q),
    .wdata_i    (alu_C),
    .raddr_a_i  (cmd_rs),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (cmd_rt),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    exec       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d     = rf_a;
          b_d     = cmd_imm_en ? sext16(cmd_imm) : rf_b;
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec       = 1'b1;
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = alu_C;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (!op_defined(op_q)) err_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Ready is masked by reset itself so no command is taken at a reset edge.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign alu_A     = (state_q == EXEC) ? a_q  : '0;
  assign alu_B     = (state_q == EXEC) ? b_q  : '0;
  assign alu_op    = (state_q == EXEC) ? op_q : '0;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign op_count  = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq + alu: transaction-level reference model checked every
// cycle, plus directed commands with hand-computed results.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt, dbg_addr;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;

  logic        cmd_ready, wb_valid, err;
  logic [31:0] alu_A, alu_B, alu_C, wb_data, dbg_data;
  logic [2:0]  alu_op, wb_addr;
  logic [15:0] op_count;

  logic        s_cmd_ready, s_wb_valid, s_err;
  logic [31:0] s_alu_A, s_alu_B, s_alu_C, s_wb_data, s_dbg_data;
  logic [2:0]  s_alu_op, s_wb_addr;
  logic [1:0]  s_op_count;

  always #5 clk = ~clk;

  alu_seq #(.NREG(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_C(alu_C),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .op_count(op_count), .err(err)
  );
  alu u_alu (.A(alu_A), .B(alu_B), .ALUOp(alu_op), .C(alu_C));

  alu_seq #(.NREG(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_A(s_alu_A), .alu_B(s_alu_B), .alu_op(s_alu_op), .alu_C(s_alu_C),
    .wb_valid(s_wb_valid), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .dbg_addr(dbg_addr), .dbg_data(s_dbg_data), .op_count(s_op_count), .err(s_err)
  );
  alu u_alu_sat (.A(s_alu_A), .B(s_alu_B), .ALUOp(s_alu_op), .C(s_alu_C));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: registers as an array, one pending transaction at a time.
  logic [31:0] m_r [8];
  logic        m_busy, m_wbv, m_err;
  logic [31:0] m_a, m_b, m_wbd, m_res;
  logic [2:0]  m_op, m_rd, m_wba;
  int unsigned m_cnt;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (b >= 32) ? 32'h0 : (a >> b[4:0]);
      3'd5: return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 32'h0;
    m_busy = 1'b0; m_wbv = 1'b0; m_err = 1'b0; m_cnt = 0;
    m_a = 32'h0; m_b = 32'h0; m_op = 3'h0; m_rd = 3'h0; m_wba = 3'h0; m_wbd = 32'h0;
  endtask

  initial begin : compare
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, (!reset && !m_busy)});
      chk("alu_A", alu_A, m_busy ? m_a : 32'h0);
      chk("alu_B", alu_B, m_busy ? m_b : 32'h0);
      chk("alu_op", {29'h0, alu_op}, m_busy ? {29'h0, m_op} : 32'h0);
      chk("wb_valid", {31'h0, wb_valid}, {31'h0, m_wbv});
      if (m_wbv) begin
        chk("wb_addr", {29'h0, wb_addr}, {29'h0, m_wba});
        chk("wb_data", wb_data, m_wbd);
      end
      chk("op_count", {16'h0, op_count}, m_cnt);
      chk("op_count_sat", {30'h0, s_op_count}, (m_cnt > 3) ? 32'd3 : m_cnt);
      chk("err", {31'h0, err}, {31'h0, m_err});
      chk("dbg_data", dbg_data, m_r[dbg_addr]);
      if (reset) begin
        model_reset();
      end else begin
        m_wbv = 1'b0;
        if (m_busy) begin
          m_res = ref_alu(m_op, m_a, m_b);
          if (m_rd != 3'd0) m_r[m_rd] = m_res;
          m_wbv = 1'b1; m_wba = m_rd; m_wbd = m_res;
          if (m_cnt < 65535) m_cnt++;
          if (m_op > 3'd5) m_err = 1'b1;
          m_busy = 1'b0;
        end else if (cmd_valid) begin
          m_a    = m_r[cmd_rs];
          m_b    = cmd_imm_en ? {{16{cmd_imm[15]}}, cmd_imm} : m_r[cmd_rt];
          m_op   = cmd_op;
          m_rd   = cmd_rd;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Presents a command and returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                       input bit hold, output int acc);
    bit got = 0;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no cmd_ready expected within 20 cycles");
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic issue_chk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                           input logic [31:0] exp, input string nm);
    int acc;
    issue(op, rd, rs, rt, ie, imm, 1'b0, acc);
    @(negedge clk);
    chk({nm, "_wb_early"}, {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    chk({nm, "_wb_pulse"}, {31'h0, wb_valid}, 32'h1);
    chk(nm, wb_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic dbg_chk(input logic [2:0] a, input logic [31:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int a0, a1, a2, base;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'h0; cmd_rd = 3'h0; cmd_rs = 3'h0;
    cmd_rt = 3'h0; cmd_imm_en = 1'b0; cmd_imm = 16'h0; dbg_addr = 3'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_count", {16'h0, op_count}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dbg_chk(3'(i), 32'h0, "rst_dbg");
    end

    issue_chk(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 32'h0000_7FFF, "add_imm_pos");
    issue_chk(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h8000, 32'hFFFF_8000, "add_imm_neg");
    issue_chk(OP_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0,    32'h0000_FFFF, "sub_rr");
    dbg_chk(3'd3, 32'h0000_FFFF, "dbg_r3");

    issue_chk(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'h8000, 32'hFFFF_8000, "load_r4");
    issue_chk(OP_SRA, 3'd6, 3'd4, 3'd0, 1'b1, 16'h0004, 32'hFFFF_F800, "sra_imm4");
    issue_chk(OP_SRL, 3'd6, 3'd4, 3'd0, 1'b1, 16'h0004, 32'h0FFF_F800, "srl_imm4");
    issue_chk(OP_SRA, 3'd6, 3'd4, 3'd2, 1'b0, 16'h0,    32'hFFFF_FFFF, "sra_big");
    issue_chk(OP_SRL, 3'd6, 3'd4, 3'd2, 1'b0, 16'h0,    32'h0000_0000, "srl_big");
    issue_chk(OP_OR,  3'd7, 3'd1, 3'd2, 1'b0, 16'h0,    32'hFFFF_FFFF, "or_rr");

    base = int'(op_count);
    issue(OP_ADD, 3'd5, 3'd1, 3'd1, 1'b0, 16'h0,    1'b1, a0);
    issue(OP_ADD, 3'd5, 3'd5, 3'd5, 1'b0, 16'h0,    1'b1, a1);
    issue(OP_AND, 3'd7, 3'd5, 3'd0, 1'b1, 16'hFFF0, 1'b0, a2);
    chk("accept_gap1", a1 - a0, 32'd2);
    chk("accept_gap2", a2 - a1, 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("chain_and", wb_data, 32'h0001_FFF0);
    @(posedge clk); #1;
    dbg_chk(3'd5, 32'h0001_FFFC, "chain_r5");
    chk("chain_count", int'(op_count) - base, 32'd3);

    issue_chk(OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 16'h0001, 32'h0000_8000, "rd0_wb");
    dbg_chk(3'd0, 32'h0, "r0_zero");

    issue_chk(3'b110, 3'd7, 3'd1, 3'd1, 1'b0, 16'h0, 32'h0, "undef_res");
    dbg_chk(3'd7, 32'h0, "undef_r7");
    chk("err_set", {31'h0, err}, 32'h1);
    issue_chk(OP_OR, 3'd6, 3'd1, 3'd0, 1'b1, 16'h0000, 32'h0000_7FFF, "or_after_err");
    chk("err_sticky", {31'h0, err}, 32'h1);
    chk("sat_count", {30'h0, s_op_count}, 32'd3);

    issue(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0005, 1'b0, a0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_wb", {31'h0, wb_valid}, 32'h0);
    chk("abort_count", {16'h0, op_count}, 32'h0);
    chk("abort_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    dbg_chk(3'd1, 32'h0, "abort_r1");

    issue_chk(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 32'h0000_0005, "post_reset_add");
    dbg_chk(3'd1, 32'h0000_0005, "post_reset_r1");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
